// File: rtl/nim_pkg.sv
// Shared definitions for the Nim board button front-end.
package nim_pkg;

  localparam int unsigned NIM_N_BTN = 5;

  function automatic int unsigned btn_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BTN_IDX_W = btn_idx_w(NIM_N_BTN);

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_SEL   = 4;

  typedef struct packed {
    logic [BTN_IDX_W-1:0] id;
    logic                 rep;
  } btn_evt_t;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, tick-based debounce, press edge detect and hold-repeat timer.
module btn_channel #(
  parameter int unsigned DB_TICKS    = 16,
  parameter int unsigned REPEAT_DLY  = 500,
  parameter int unsigned REPEAT_RATE = 100,
  parameter bit          REPEAT_EN   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic evt_pulse_c,
  output logic evt_rep_c
);

  localparam int unsigned CW   = $clog2(DB_TICKS) + 1;
  localparam int unsigned HMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned HW   = $clog2(HMAX) + 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;
  logic          first;
  logic          differ;
  logic          accept;
  logic          rise;
  logic          fall;
  logic          hold_due;
  logic [HW-1:0] target;

  assign differ   = sync_q[1] ^ level;
  assign accept   = tick && differ && (cnt == CW'(DB_TICKS - 1));
  assign rise     = accept && sync_q[1];
  assign fall     = accept && !sync_q[1];
  assign target   = first ? HW'(REPEAT_DLY - 1) : HW'(REPEAT_RATE - 1);
  // A hold that is ending on this tick no longer repeats.
  assign hold_due = tick && level && !fall && (hcnt == target);

  assign evt_pulse_c = rise;
  assign evt_rep_c   = REPEAT_EN && hold_due;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      hcnt   <= '0;
      first  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (tick) begin
        if (!differ) begin
          cnt <= '0;
        end else if (accept) begin
          cnt   <= '0;
          level <= sync_q[1];
        end else begin
          cnt <= cnt + CW'(1);
        end

        // Hold timer: first interval is the initial delay, then the repeat rate.
        if (rise || fall) begin
          hcnt  <= '0;
          first <= 1'b1;
        end else if (level) begin
          if (hold_due) begin
            hcnt  <= '0;
            first <= 1'b0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Button front-end: shared sample prescaler, per-button channels, and a round-robin event queue.
module button_event_ctrl
  import nim_pkg::*;
#(
  parameter int unsigned     N_BTN       = 5,
  parameter int unsigned     TICK_DIV    = 1000,
  parameter int unsigned     DB_TICKS    = 16,
  parameter int unsigned     REPEAT_DLY  = 500,
  parameter int unsigned     REPEAT_RATE = 100,
  parameter logic [N_BTN-1:0] REPEAT_EN  = {N_BTN{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BTN-1:0]           btn_raw,
  output logic [N_BTN-1:0]           btn_level,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(N_BTN)-1:0]   evt_id,
  output logic                       evt_repeat,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned IDW = btn_idx_w(N_BTN);
  localparam int unsigned IW1 = IDW + 1;
  localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rep_hit;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] pend_rep;
  logic [N_BTN-1:0] take;
  logic [N_BTN-1:0] drop;
  logic [IDW-1:0]   rr;
  logic [IDW-1:0]   sel;
  logic [IW1-1:0]   idx_w;
  logic             found;
  logic             load;

  assign tick = (pcnt == PW'(TICK_DIV - 1));
  assign load = !evt_valid || evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DB_TICKS   (DB_TICKS),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE),
      .REPEAT_EN  (REPEAT_EN[g])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (btn_raw[g]),
      .tick       (tick),
      .level      (btn_level[g]),
      .evt_pulse_c(press[g]),
      .evt_rep_c  (rep_hit[g])
    );
  end

  // Round-robin search for the first pending channel at or above the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx_w = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx_w = IW1'(rr) + IW1'(k);
      if (idx_w >= IW1'(N_BTN)) idx_w = idx_w - IW1'(N_BTN);
      if (!found && pend[IDW'(idx_w)]) begin
        found = 1'b1;
        sel   = IDW'(idx_w);
      end
    end
  end

  // A new event is dropped only if its channel is still pending and not being loaded now.
  always_comb begin
    take = '0;
    drop = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      take[i] = load && found && (sel == IDW'(i));
      drop[i] = (press[i] || rep_hit[i]) && pend[i] && !take[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_rep   <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= 1'b0;
      overflow   <= 1'b0;
      rr         <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if ((press[i] || rep_hit[i]) && !drop[i]) begin
          pend[i]     <= 1'b1;
          pend_rep[i] <= !press[i];
        end else if (take[i]) begin
          pend[i] <= 1'b0;
        end
      end

      if (|drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id     <= sel;
          evt_repeat <= pend_rep[sel];
          rr         <= (sel == IDW'(N_BTN - 1)) ? '0 : sel + IDW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scenario tasks plus a randomized run checked against a tick-level behavioural model.
module tb_button_event_ctrl;

  localparam int N     = 4;
  localparam int TD    = 4;
  localparam int DB    = 3;
  localparam int RD    = 5;
  localparam int RRATE = 2;
  localparam logic [N-1:0] REN = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic         evt_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_repeat;
  logic         overflow;

  int n_checks = 0;
  int n_fail = 0;

  button_event_ctrl #(
    .N_BTN(N), .TICK_DIV(TD), .DB_TICKS(DB),
    .REPEAT_DLY(RD), .REPEAT_RATE(RRATE), .REPEAT_EN(REN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_repeat(evt_repeat), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference: streaks of differing ticks, absolute hold-tick count, RR search by modulo.
  bit [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_prep;
  int         m_streak [N];
  int         m_hold [N];
  bit         m_valid, m_rep, m_ovf;
  int         m_id, m_rr, m_cyc;

  always @(posedge clk or negedge rst_n) begin : model
    bit tk, load, found, ovf_set;
    int take;
    bit [N-1:0] ev_new, ev_rep;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_prep = '0;
      for (int i = 0; i < N; i++) begin m_streak[i] = 0; m_hold[i] = 0; end
      m_valid = 0; m_rep = 0; m_ovf = 0; m_id = 0; m_rr = 0; m_cyc = 0;
    end else begin
      tk = (m_cyc % TD) == TD - 1;
      m_cyc++;
      ev_new = '0; ev_rep = '0;
      if (tk) begin
        for (int i = 0; i < N; i++) begin
          m_streak[i] = (m_s2[i] != m_lvl[i]) ? m_streak[i] + 1 : 0;
          if (m_streak[i] == DB) begin
            m_lvl[i] = m_s2[i];
            m_streak[i] = 0;
            m_hold[i] = 0;
            if (m_lvl[i]) ev_new[i] = 1;
          end else if (m_lvl[i]) begin
            m_hold[i]++;
            if (REN[i] && (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RRATE == 0))) begin
              ev_new[i] = 1; ev_rep[i] = 1;
            end
          end
        end
      end
      m_s2 = m_s1; m_s1 = btn_raw;
      load = !m_valid || evt_ready;
      found = 0; take = -1;
      for (int j = 0; j < N; j++)
        if (!found && m_pend[(m_rr + j) % N]) begin found = 1; take = (m_rr + j) % N; end
      if (load) begin
        m_valid = found;
        if (found) begin m_id = take; m_rep = m_prep[take]; m_rr = (take + 1) % N; end
      end else begin
        take = -1;
      end
      ovf_set = 0;
      for (int i = 0; i < N; i++) begin
        if (ev_new[i]) begin
          if (m_pend[i] && take != i) ovf_set = 1;
          else begin m_pend[i] = 1; m_prep[i] = ev_rep[i]; end
        end else if (take == i) begin
          m_pend[i] = 0;
        end
      end
      if (ovf_set) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    btn_raw = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({btn_level, evt_valid, evt_id, evt_repeat, overflow} !== 9'b0) begin
      n_fail++; $display("FAIL reset_hold got=%b exp=0", {btn_level, evt_valid, evt_id, evt_repeat, overflow});
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({btn_level, evt_valid, evt_id, evt_repeat, overflow} !== 9'b0) begin
      n_fail++; $display("FAIL reset_release got=%b exp=0", {btn_level, evt_valid, evt_id, evt_repeat, overflow});
    end
  endtask

  task automatic test_glitch;
    btn_raw[0] = 1'b1;
    repeat (2 * TD) @(negedge clk);
    btn_raw[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++;
      if (btn_level[0] !== 1'b0 || evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL glitch c=%0d level0=%b valid=%b exp 0,0", c, btn_level[0], evt_valid);
      end
    end
  endtask

  task automatic test_clean_press;
    int k, ev;
    evt_ready = 1'b1;
    btn_raw[2] = 1'b1;
    k = 0;
    while (!btn_level[2] && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (k < 11 || k > 14) begin n_fail++; $display("FAIL press_latency got=%0d exp 11..14", k); end
    n_checks++;
    if ({btn_level, evt_valid} !== 5'b0100_0) begin
      n_fail++; $display("FAIL press_level got=%b exp=01000", {btn_level, evt_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_id, evt_repeat} !== 4'b1_10_0) begin
      n_fail++; $display("FAIL press_event got=%b exp=1100", {evt_valid, evt_id, evt_repeat});
    end
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL press_drop got=%b exp=0", evt_valid); end
    btn_raw[2] = 1'b0;
    k = 0; ev = 0;
    while (btn_level[2] && k < 40) begin @(negedge clk); k++; if (evt_valid) ev++; end
    n_checks++;
    if (btn_level[2] !== 1'b0 || ev != 0) begin
      n_fail++; $display("FAIL release level=%b events=%0d exp 0,0", btn_level[2], ev);
    end
  endtask

  task automatic test_simultaneous;
    int k;
    logic [1:0] exp_ids [3];
    exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd3;
    evt_ready = 1'b1;
    do_reset();
    btn_raw = 4'b1011;
    k = 0;
    while (!evt_valid && k < 40) begin @(negedge clk); k++; end
    for (int e = 0; e < 3; e++) begin
      n_checks++;
      if ({evt_valid, evt_id, evt_repeat} !== {1'b1, exp_ids[e], 1'b0}) begin
        n_fail++; $display("FAIL simul_%0d got=%b exp=1%b0", e, {evt_valid, evt_id, evt_repeat}, exp_ids[e]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL simul_end got=%b exp=0", evt_valid); end
    btn_raw = '0;
    k = 0;
    while (btn_level != 0 && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    btn_raw = 4'b1001;
    k = 0;
    while (!evt_valid && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if ({evt_valid, evt_id} !== 3'b1_00) begin n_fail++; $display("FAIL simul2_first got=%b exp=100", {evt_valid, evt_id}); end
    @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_id} !== 3'b1_11) begin n_fail++; $display("FAIL simul2_second got=%b exp=111", {evt_valid, evt_id}); end
    btn_raw = '0;
    k = 0;
    while (btn_level != 0 && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (btn_level !== 4'b0) begin n_fail++; $display("FAIL simul2_release got=%b exp=0", btn_level); end
  endtask

  task automatic test_overflow;
    int k, hs;
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_raw[1] = 1'b1;
      k = 0;
      while (!btn_level[1] && k < 40) begin @(negedge clk); k++; end
      @(negedge clk);
      n_checks++;
      if ({evt_valid, evt_id, overflow} !== {1'b1, 2'd1, (p == 2)}) begin
        n_fail++; $display("FAIL ovf_press%0d got=%b exp=101%0d", p, {evt_valid, evt_id, overflow}, (p == 2));
      end
      btn_raw[1] = 1'b0;
      k = 0;
      while (btn_level[1] && k < 40) begin @(negedge clk); k++; end
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if ({overflow, evt_valid, evt_id} !== 4'b0_1_01) begin
      n_fail++; $display("FAIL ovf_clear got=%b exp=0101", {overflow, evt_valid, evt_id});
    end
    evt_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (evt_valid) hs++;
      @(negedge clk);
    end
    n_checks++;
    if (hs != 2) begin n_fail++; $display("FAIL ovf_drain got=%0d exp=2", hs); end
  endtask

  task automatic test_auto_repeat(input int b, input int exp_reps);
    int k, np, nr, nw;
    evt_ready = 1'b1;
    btn_raw[b] = 1'b1;
    k = 0;
    while (!btn_level[b] && k < 40) begin @(negedge clk); k++; end
    np = 0; nr = 0; nw = 0;
    for (int c = 0; c < 12 * TD; c++) begin
      @(negedge clk);
      if (evt_valid) begin
        if (evt_id != 2'(b)) nw++;
        else if (evt_repeat) nr++;
        else np++;
      end
    end
    n_checks++;
    if (np != 1 || nr != exp_reps || nw != 0) begin
      n_fail++; $display("FAIL repeat_btn%0d press=%0d reps=%0d other=%0d exp 1,%0d,0", b, np, nr, nw, exp_reps);
    end
    btn_raw[b] = 1'b0;
    k = 0;
    while (btn_level[b] && k < 40) begin @(negedge clk); k++; end
    nr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (evt_valid) nr++;
    end
    n_checks++;
    if (btn_level[b] !== 1'b0 || nr != 0) begin
      n_fail++; $display("FAIL repeat_stop_btn%0d level=%b events=%0d exp 0,0", b, btn_level[b], nr);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    k = 0;
    while (!btn_level[2] && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    btn_raw[0] = 1'b1;
    k = 0;
    while (m_streak[0] != 2 && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (evt_valid !== 1'b1 || m_streak[0] != 2) begin
      n_fail++; $display("FAIL rmid_setup valid=%b streak=%0d exp 1,2", evt_valid, m_streak[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, evt_valid, evt_id, evt_repeat, overflow} !== 9'b0) begin
      n_fail++; $display("FAIL rmid_async got=%b exp=0", {btn_level, evt_valid, evt_id, evt_repeat, overflow});
    end
    btn_raw[2] = 1'b0;
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!evt_valid && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (k != 13 || {evt_id, evt_repeat, btn_level} !== 7'b00_0_0001) begin
      n_fail++; $display("FAIL rmid_press clk=%0d got=%b exp clk=13 0000001", k, {evt_id, evt_repeat, btn_level});
    end
    btn_raw[0] = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_random;
    int dur [N];
    logic [8:0] got, exp;
    btn_raw = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        dur[i]--;
        if (dur[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          dur[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : $urandom_range(20, 90);
        end
      end
      evt_ready = (c % 500 < 200) ? 1'b0 : ($urandom_range(0, 9) < 7);
      ovf_clr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      exp = {m_lvl, m_valid, 2'(m_id), m_rep, m_ovf};
      got = {btn_level, evt_valid, evt_id, evt_repeat, overflow};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL random c=%0d got=%b exp=%b (lvl,valid,id,rep,ovf)", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_simultaneous();
    test_overflow();
    test_auto_repeat(3, 4);
    test_auto_repeat(2, 0);
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
